// File: rtl/interrupt_controller.sv
// Interrupt controller: sticky IN/OUT/QNT pending bits, priority presentation FSM with ack handshake.
// Define INTRPT_QUANTUM_EN to build the quantum counter and the QNT (cause 11) source.
module interrupt_controller #(
  parameter int unsigned                 QUANTUM      = 10,
  parameter int unsigned                 OPCODE_WIDTH = 6,
  parameter int unsigned                 TIMER_WIDTH  = 5,
  parameter int unsigned                 PROC_WIDTH   = 2,
  parameter logic [OPCODE_WIDTH-1:0]     OPC_INPUT    = 6'b100101,
  parameter logic [OPCODE_WIDTH-1:0]     OPC_OUTPUT   = 6'b111111
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    instr_valid,
  input  logic [PROC_WIDTH-1:0]   proc_num,
  input  logic                    intrpt_ack,
  output logic                    intrpt,
  output logic [1:0]              intrpt_cause,
  output logic [PROC_WIDTH-1:0]   intrpt_proc,
  output logic [TIMER_WIDTH-1:0]  timer
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_intrpt;
  logic [1:0]            r_cause;
  logic [PROC_WIDTH-1:0] r_proc;

  logic                  r_pend_in, r_pend_out, r_pend_qnt;
  logic [PROC_WIDTH-1:0] r_proc_in, r_proc_out, r_proc_qnt;

  logic w_ev_in, w_ev_out, w_ev_qnt;
  logic w_serve, w_clr_in, w_clr_out, w_clr_qnt;

  assign w_ev_in  = instr_valid && (opcode == OPC_INPUT);
  assign w_ev_out = instr_valid && (opcode == OPC_OUTPUT);

  assign w_serve   = (r_state == S_ASSERT) && intrpt_ack;
  assign w_clr_in  = w_serve && (r_cause == 2'b01);
  assign w_clr_out = w_serve && (r_cause == 2'b10);
  assign w_clr_qnt = w_serve && (r_cause == 2'b11);

`ifdef INTRPT_QUANTUM_EN
  localparam logic [TIMER_WIDTH-1:0] LP_QLAST = TIMER_WIDTH'(QUANTUM - 1);

  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   w_count, w_wrap;

  // Only retiring non-I/O work of a user process, observed while idle, consumes the slice.
  assign w_count = instr_valid && !w_ev_in && !w_ev_out &&
                   (proc_num != '0) && (r_state == S_IDLE);
  assign w_wrap  = w_count && (r_timer == LP_QLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_ev_in || w_ev_out || w_wrap) begin
      r_timer <= '0;
    end else if (w_count) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_ev_qnt = w_wrap;
  assign timer    = r_timer;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^QUANTUM;
  assign w_ev_qnt     = 1'b0;
  assign timer        = '0;
`endif

  // A new event on the service edge re-arms its bit, so set takes priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_in  <= 1'b0;
      r_pend_out <= 1'b0;
      r_pend_qnt <= 1'b0;
      r_proc_in  <= '0;
      r_proc_out <= '0;
      r_proc_qnt <= '0;
    end else begin
      r_pend_in  <= (r_pend_in  && !w_clr_in)  || w_ev_in;
      r_pend_out <= (r_pend_out && !w_clr_out) || w_ev_out;
      r_pend_qnt <= (r_pend_qnt && !w_clr_qnt) || w_ev_qnt;
      if (w_ev_in)  r_proc_in  <= proc_num;
      if (w_ev_out) r_proc_out <= proc_num;
      if (w_ev_qnt) r_proc_qnt <= proc_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_intrpt <= 1'b0;
      r_cause  <= 2'b00;
      r_proc   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_pend_in) begin
            r_state  <= S_ASSERT;
            r_intrpt <= 1'b1;
            r_cause  <= 2'b01;
            r_proc   <= r_proc_in;
          end else if (r_pend_out) begin
            r_state  <= S_ASSERT;
            r_intrpt <= 1'b1;
            r_cause  <= 2'b10;
            r_proc   <= r_proc_out;
          end else if (r_pend_qnt) begin
            r_state  <= S_ASSERT;
            r_intrpt <= 1'b1;
            r_cause  <= 2'b11;
            r_proc   <= r_proc_qnt;
          end
        end
        S_ASSERT: begin
          if (intrpt_ack) begin
            r_state  <= S_RELEASE;
            r_intrpt <= 1'b0;
            r_cause  <= 2'b00;
          end
        end
        S_RELEASE: begin
          if (!intrpt_ack) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_intrpt <= 1'b0;
          r_cause  <= 2'b00;
        end
      endcase
    end
  end

  assign intrpt       = r_intrpt;
  assign intrpt_cause = r_cause;
  assign intrpt_proc  = r_proc;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; quantum scenarios built when INTRPT_QUANTUM_EN is defined.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       intrpt_ack = 1'b0;
  logic [5:0] opcode = '0;
  logic [1:0] proc_num = '0;

  logic       intrpt;
  logic [1:0] intrpt_cause;
  logic [1:0] intrpt_proc;
  logic [4:0] timer;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] OPI = 6'b100101;
  localparam logic [5:0] OPO = 6'b111111;
  localparam logic [5:0] ALU = 6'b000011;

  always #5 clk = ~clk;

  interrupt_controller u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .proc_num     (proc_num),
    .intrpt_ack   (intrpt_ack),
    .intrpt       (intrpt),
    .intrpt_cause (intrpt_cause),
    .intrpt_proc  (intrpt_proc),
    .timer        (timer)
  );

`ifdef INTRPT_QUANTUM_EN
  logic       q1_intrpt;
  logic [1:0] q1_cause;
  logic [1:0] q1_proc;
  logic [4:0] q1_timer;

  // One-instruction slice: lets QNT become pending while another cause is being presented.
  interrupt_controller #(.QUANTUM(1)) u_q1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .proc_num     (proc_num),
    .intrpt_ack   (intrpt_ack),
    .intrpt       (q1_intrpt),
    .intrpt_cause (q1_cause),
    .intrpt_proc  (q1_proc),
    .timer        (q1_timer)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [1:0] p, input logic a);
    instr_valid = v;
    opcode      = op;
    proc_num    = p;
    intrpt_ack  = a;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_high(output int lows, output bit seen);
    lows = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (intrpt === 1'b1) seen = 1'b1;
      else begin
        lows++;
        step();
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, OPI, 2'd1, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    checks++; if (intrpt !== 1'b0) begin failures++; $display("FAIL reset_intrpt: got %b want 0", intrpt); end
    checks++; if (intrpt_cause !== 2'b00) begin failures++; $display("FAIL reset_cause: got %b want 00", intrpt_cause); end
    checks++; if (intrpt_proc !== 2'd0) begin failures++; $display("FAIL reset_proc: got %0d want 0", intrpt_proc); end
    checks++; if (timer !== 5'd0) begin failures++; $display("FAIL reset_timer: got %0d want 0", timer); end
    drive(1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    checks++; if (intrpt !== 1'b0) begin failures++; $display("FAIL reset_no_event: got %b want 0", intrpt); end
  endtask

  task automatic test_output();
    bit stable_ok;
    drive(1'b1, OPO, 2'd2, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (intrpt !== 1'b1 || intrpt_cause !== 2'b10 || intrpt_proc !== 2'd2) begin
      failures++; $display("FAIL output_present: got intrpt=%b cause=%b proc=%0d want 1/10/2", intrpt, intrpt_cause, intrpt_proc);
    end
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (intrpt !== 1'b1 || intrpt_cause !== 2'b10 || intrpt_proc !== 2'd2) stable_ok = 1'b0;
    end
    checks++; if (!stable_ok) begin failures++; $display("FAIL output_hold: got unstable want held 1/10/2 for 5 cycles"); end
    drive(1'b0, '0, '0, 1'b1);
    step();
    checks++; if (intrpt !== 1'b0 || intrpt_cause !== 2'b00) begin
      failures++; $display("FAIL output_ack_drop: got intrpt=%b cause=%b want 0/00", intrpt, intrpt_cause);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    step();
    checks++; if (intrpt !== 1'b0) begin failures++; $display("FAIL output_cleared: got %b want 0", intrpt); end
  endtask

  task automatic test_ack_idle();
    bit seen_hi;
    seen_hi = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (intrpt !== 1'b0) seen_hi = 1'b1;
    end
    checks++; if (seen_hi) begin failures++; $display("FAIL ack_idle: got intrpt high want low"); end
    drive(1'b0, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_input_proc0();
    drive(1'b1, OPI, 2'd0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (intrpt !== 1'b1 || intrpt_cause !== 2'b01 || intrpt_proc !== 2'd0) begin
      failures++; $display("FAIL input_proc0: got intrpt=%b cause=%b proc=%0d want 1/01/0", intrpt, intrpt_cause, intrpt_proc);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_priority();
    int  lows;
    bit  seen;
    drive(1'b1, OPI, 2'd1, 1'b0);
    step();
    drive(1'b1, OPO, 2'd3, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (intrpt !== 1'b1 || intrpt_cause !== 2'b01 || intrpt_proc !== 2'd1) begin
      failures++; $display("FAIL prio_first: got intrpt=%b cause=%b proc=%0d want 1/01/1", intrpt, intrpt_cause, intrpt_proc);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    checks++; if (intrpt !== 1'b0 || intrpt_cause !== 2'b00) begin
      failures++; $display("FAIL prio_release: got intrpt=%b cause=%b want 0/00", intrpt, intrpt_cause);
    end
    drive(1'b0, '0, '0, 1'b0);
    wait_high(lows, seen);
    checks++; if (!seen || lows != 2) begin
      failures++; $display("FAIL prio_gap: got seen=%b low_cycles=%0d want seen=1 low_cycles=2", seen, lows);
    end
    checks++; if (intrpt_cause !== 2'b10 || intrpt_proc !== 2'd3) begin
      failures++; $display("FAIL prio_second: got cause=%b proc=%0d want 10/3", intrpt_cause, intrpt_proc);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    step();
    checks++; if (intrpt !== 1'b0) begin failures++; $display("FAIL prio_drained: got %b want 0", intrpt); end
  endtask

  task automatic test_set_wins();
    int lows;
    bit seen;
    drive(1'b1, OPI, 2'd1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (intrpt !== 1'b1 || intrpt_cause !== 2'b01 || intrpt_proc !== 2'd1) begin
      failures++; $display("FAIL setwin_first: got intrpt=%b cause=%b proc=%0d want 1/01/1", intrpt, intrpt_cause, intrpt_proc);
    end
    drive(1'b1, OPI, 2'd2, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    wait_high(lows, seen);
    checks++; if (!seen || intrpt_cause !== 2'b01 || intrpt_proc !== 2'd2) begin
      failures++; $display("FAIL setwin_reassert: got seen=%b cause=%b proc=%0d want 1/01/2", seen, intrpt_cause, intrpt_proc);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    step();
    checks++; if (intrpt !== 1'b0) begin failures++; $display("FAIL setwin_drained: got %b want 0", intrpt); end
  endtask

  task automatic test_proc0_alu();
    bit bad;
    bad = 1'b0;
    drive(1'b1, ALU, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (timer !== 5'd0 || intrpt !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL proc0_alu: got timer=%0d intrpt=%b want timer 0 intrpt 0 throughout", timer, intrpt); end
    drive(1'b0, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_reset_mid();
    bit seen_hi;
    drive(1'b1, OPI, 2'd1, 1'b0);
    step();
    drive(1'b1, OPO, 2'd1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    checks++; if (intrpt !== 1'b1) begin failures++; $display("FAIL rstmid_assert: got %b want 1", intrpt); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (intrpt !== 1'b0 || intrpt_cause !== 2'b00 || intrpt_proc !== 2'd0) begin
      failures++; $display("FAIL rstmid_async: got intrpt=%b cause=%b proc=%0d want 0/00/0", intrpt, intrpt_cause, intrpt_proc);
    end
    step();
    rst_n = 1'b1;
    seen_hi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (intrpt !== 1'b0) seen_hi = 1'b1;
    end
    checks++; if (seen_hi) begin failures++; $display("FAIL rstmid_discard: got intrpt high after reset want low"); end
  endtask

`ifdef INTRPT_QUANTUM_EN
  task automatic test_quantum();
    do_reset();
    drive(1'b1, ALU, 2'd1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3) begin
        checks++; if (timer !== 5'd3) begin failures++; $display("FAIL qnt_count3: got %0d want 3", timer); end
      end
      if (i == 9) begin
        checks++; if (timer !== 5'd9 || intrpt !== 1'b0) begin
          failures++; $display("FAIL qnt_count9: got timer=%0d intrpt=%b want 9/0", timer, intrpt);
        end
      end
    end
    checks++; if (timer !== 5'd0 || intrpt !== 1'b0) begin
      failures++; $display("FAIL qnt_wrap: got timer=%0d intrpt=%b want 0/0", timer, intrpt);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    checks++; if (intrpt !== 1'b1 || intrpt_cause !== 2'b11 || intrpt_proc !== 2'd1) begin
      failures++; $display("FAIL qnt_present: got intrpt=%b cause=%b proc=%0d want 1/11/1", intrpt, intrpt_cause, intrpt_proc);
    end
    step();
    checks++; if (intrpt !== 1'b0 || intrpt_cause !== 2'b00) begin
      failures++; $display("FAIL qnt_drop: got intrpt=%b cause=%b want 0/00", intrpt, intrpt_cause);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    checks++; if (intrpt !== 1'b0) begin failures++; $display("FAIL qnt_drained: got %b want 0", intrpt); end
  endtask

  task automatic test_timer_rules();
    drive(1'b1, ALU, 2'd1, 1'b0);
    step(); step(); step();
    drive(1'b0, ALU, 2'd1, 1'b0);
    step();
    checks++; if (timer !== 5'd3) begin failures++; $display("FAIL tmr_hold_invalid: got %0d want 3", timer); end
    drive(1'b1, OPO, 2'd1, 1'b0);
    step();
    checks++; if (timer !== 5'd0) begin failures++; $display("FAIL tmr_io_clear: got %0d want 0", timer); end
    drive(1'b1, ALU, 2'd1, 1'b0);
    step();
    step();
    checks++; if (timer !== 5'd1 || intrpt !== 1'b1 || intrpt_cause !== 2'b10) begin
      failures++; $display("FAIL tmr_hold_busy: got timer=%0d intrpt=%b cause=%b want 1/1/10", timer, intrpt, intrpt_cause);
    end
    drive(1'b1, ALU, 2'd1, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (timer !== 5'd1 || intrpt !== 1'b0) begin
      failures++; $display("FAIL tmr_after_serve: got timer=%0d intrpt=%b want 1/0", timer, intrpt);
    end
  endtask

  task automatic test_simul_q1();
    int lows;
    do_reset();
    drive(1'b1, OPO, 2'd1, 1'b0);
    step();
    drive(1'b1, ALU, 2'd1, 1'b0);
    step();
    checks++; if (q1_intrpt !== 1'b1 || q1_cause !== 2'b10) begin
      failures++; $display("FAIL simul_out: got intrpt=%b cause=%b want 1/10", q1_intrpt, q1_cause);
    end
    drive(1'b1, OPI, 2'd2, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    checks++; if (q1_intrpt !== 1'b1 || q1_cause !== 2'b01 || q1_proc !== 2'd2) begin
      failures++; $display("FAIL simul_in_first: got intrpt=%b cause=%b proc=%0d want 1/01/2", q1_intrpt, q1_cause, q1_proc);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    lows = 0;
    for (int i = 0; i < 10 && q1_intrpt !== 1'b1; i++) begin
      lows++;
      step();
    end
    checks++; if (q1_intrpt !== 1'b1 || q1_cause !== 2'b11 || q1_proc !== 2'd1) begin
      failures++; $display("FAIL simul_qnt_next: got intrpt=%b cause=%b proc=%0d want 1/11/1", q1_intrpt, q1_cause, q1_proc);
    end
    checks++; if (lows < 2) begin failures++; $display("FAIL simul_gap: got %0d low cycles want >=2", lows); end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
    step();
    checks++; if (q1_intrpt !== 1'b0) begin failures++; $display("FAIL simul_drained: got %b want 0", q1_intrpt); end
    do_reset();
  endtask
`else
  task automatic test_no_quantum();
    bit bad;
    bad = 1'b0;
    drive(1'b1, ALU, 2'd1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (timer !== 5'd0 || intrpt !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL noqnt_alu: got timer=%0d intrpt=%b want 0/0 throughout", timer, intrpt); end
    drive(1'b1, OPI, 2'd1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    checks++; if (intrpt !== 1'b1 || intrpt_cause !== 2'b01) begin
      failures++; $display("FAIL noqnt_input: got intrpt=%b cause=%b want 1/01", intrpt, intrpt_cause);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    step();
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_output();
    test_ack_idle();
    test_input_proc0();
    test_priority();
    test_set_wins();
    test_proc0_alu();
`ifdef INTRPT_QUANTUM_EN
    test_quantum();
    test_timer_rules();
    test_simul_q1();
`else
    test_no_quantum();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
